// File: rtl/dpll_ctrl_mc.sv
// DPLL solver control FSM: imply/decide/backtrack sequencing with NUM_BCP parallel BCP engines.
// Optional DPLL_STATS_EN adds saturating decision/conflict counters.
module dpll_bcp_lane #(
  parameter int CLAUSE_BITS = 10
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   issue_d,
  input  logic [CLAUSE_BITS-1:0] idx_d,
  input  logic                   done,
  output logic                   pending,
  output logic                   issue,
  output logic [CLAUSE_BITS-1:0] clause_idx
);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= 1'b0;
      issue      <= 1'b0;
      clause_idx <= '0;
    end else begin
      issue   <= issue_d;
      pending <= issue_d | (pending & ~done);
      if (issue_d) clause_idx <= idx_d;
    end
  end
endmodule

module dpll_ctrl_mc #(
  parameter int VAR_BITS    = 8,
  parameter int CLAUSE_BITS = 10,
  parameter int NUM_BCP     = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  output logic                           sat,
  output logic                           unsat,
  input  logic                           imply_empty,
  input  logic [VAR_BITS:0]              imply_head,
  output logic                           imply_pop,
  output logic                           imply_flush,
  input  logic                           trace_empty,
  input  logic [VAR_BITS+1:0]            trace_head,
  output logic                           trace_pop,
  output logic                           trace_push,
  output logic [VAR_BITS+1:0]            trace_din,
  output logic                           vs_write,
  output logic [VAR_BITS+1:0]            vs_data,
  output logic                           vse_read,
  input  logic [2*CLAUSE_BITS-1:0]       vse_range,
  output logic                           dec_req,
  input  logic                           dec_valid,
  input  logic                           dec_none,
  input  logic [VAR_BITS:0]              dec_head,
  output logic [NUM_BCP-1:0]             bcp_issue,
  output logic [NUM_BCP*CLAUSE_BITS-1:0] bcp_clause_idx,
  input  logic [NUM_BCP-1:0]             bcp_done,
  input  logic [NUM_BCP-1:0]             bcp_conflict,
  output logic                           bcp_clear
`ifdef DPLL_STATS_EN
  ,
  output logic [15:0]                    num_decisions,
  output logic [15:0]                    num_conflicts
`endif
);
  typedef enum logic [3:0] {
    S_IDLE, S_FIND, S_DECIDE, S_VSE_RD, S_VSE_LAT,
    S_DISPATCH, S_DRAIN, S_BACKTRACK, S_SAT, S_UNSAT
  } state_t;

  localparam logic [CLAUSE_BITS:0] ONE = {{CLAUSE_BITS{1'b0}}, 1'b1};

  state_t state, nxt;
  logic [CLAUSE_BITS-1:0] idx, idx_d, end_r, end_d;
  logic conf_flag, conf_d, bt_hold, hold_d, conf_now, conf_any;
  logic ipop_d, flush_d, tpop_d, tpush_d, vsw_d, vser_d, clear_d;
  logic [VAR_BITS+1:0] tdin_d, vsd_d;
  logic [NUM_BCP-1:0] pending, pend_after, lane_iss;
  logic [NUM_BCP-1:0][CLAUSE_BITS-1:0] lane_idx, lane_cidx;
  logic [CLAUSE_BITS:0] iss_nxt;
  logic iss_en;

  wire [CLAUSE_BITS-1:0] rng_start = vse_range[2*CLAUSE_BITS-1:CLAUSE_BITS];
  wire [CLAUSE_BITS-1:0] rng_end   = vse_range[CLAUSE_BITS-1:0];

  genvar g;
  generate
    for (g = 0; g < NUM_BCP; g++) begin : g_lane
      dpll_bcp_lane #(.CLAUSE_BITS(CLAUSE_BITS)) u_lane (
        .clock(clock), .reset_n(reset_n), .issue_d(lane_iss[g]), .idx_d(lane_idx[g]),
        .done(bcp_done[g]), .pending(pending[g]), .issue(bcp_issue[g]),
        .clause_idx(lane_cidx[g])
      );
    end
  endgenerate
  assign bcp_clause_idx = lane_cidx;

  assign conf_now   = ((state == S_DISPATCH) || (state == S_DRAIN)) && |(bcp_done & bcp_conflict);
  assign conf_any   = conf_flag | conf_now;
  assign pend_after = pending & ~bcp_done;
  assign iss_en     = (state == S_DISPATCH) && !conf_any;

  // Free engines (done-this-cycle still counts as busy) take consecutive indices in ascending order.
  always_comb begin
    lane_iss = '0;
    lane_idx = '0;
    iss_nxt  = {1'b0, idx};
    for (int k = 0; k < NUM_BCP; k++) begin
      lane_idx[k] = iss_nxt[CLAUSE_BITS-1:0];
      if (iss_en && !pending[k] && (iss_nxt < {1'b0, end_r})) begin
        lane_iss[k] = 1'b1;
        iss_nxt     = iss_nxt + ONE;
      end
    end
  end

  always_comb begin
    nxt = state; idx_d = idx; end_d = end_r; hold_d = 1'b0;
    conf_d = conf_flag | conf_now;
    ipop_d = 1'b0; flush_d = conf_now & ~conf_flag; tpop_d = 1'b0; tpush_d = 1'b0;
    vsw_d = 1'b0; vser_d = 1'b0; clear_d = 1'b0;
    tdin_d = trace_din; vsd_d = vs_data;
    case (state)
      S_IDLE: if (start) nxt = S_FIND;
      S_FIND: begin
        if (!imply_empty) begin
          ipop_d = 1'b1; tpush_d = 1'b1; tdin_d = {1'b1, imply_head};
          vsw_d = 1'b1; vsd_d = {1'b0, imply_head}; vser_d = 1'b1;
          nxt = S_VSE_RD;
        end else nxt = S_DECIDE;
      end
      S_DECIDE: begin
        if (dec_valid) begin
          if (dec_none) nxt = S_SAT;
          else begin
            tpush_d = 1'b1; tdin_d = {1'b0, dec_head};
            vsw_d = 1'b1; vsd_d = {1'b0, dec_head}; vser_d = 1'b1;
            nxt = S_VSE_RD;
          end
        end
      end
      S_VSE_RD: nxt = S_VSE_LAT;
      S_VSE_LAT: begin
        idx_d = rng_start; end_d = rng_end;
        nxt = (rng_end <= rng_start) ? S_FIND : S_DISPATCH;
      end
      S_DISPATCH: begin
        if (conf_any) begin
          if (pend_after == '0) begin clear_d = 1'b1; conf_d = 1'b0; nxt = S_BACKTRACK; end
          else nxt = S_DRAIN;
        end else begin
          idx_d = iss_nxt[CLAUSE_BITS-1:0];
          if (iss_nxt == {1'b0, end_r}) nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pend_after == '0) begin
          if (conf_any) begin clear_d = 1'b1; conf_d = 1'b0; nxt = S_BACKTRACK; end
          else nxt = S_FIND;
        end
      end
      S_BACKTRACK: begin
        // bt_hold gives the stack one cycle to expose the new head after a registered pop.
        if (bt_hold) nxt = S_BACKTRACK;
        else if (trace_empty) nxt = S_UNSAT;
        else if (trace_head[VAR_BITS+1]) begin
          tpop_d = 1'b1; vsw_d = 1'b1; vsd_d = {1'b1, trace_head[VAR_BITS:0]}; hold_d = 1'b1;
        end else begin
          tpop_d = 1'b1; tpush_d = 1'b1;
          tdin_d = {1'b1, ~trace_head[VAR_BITS], trace_head[VAR_BITS-1:0]};
          vsw_d = 1'b1; vsd_d = {1'b0, ~trace_head[VAR_BITS], trace_head[VAR_BITS-1:0]};
          vser_d = 1'b1; nxt = S_VSE_RD;
        end
      end
      default: nxt = state;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE; idx <= '0; end_r <= '0; conf_flag <= 1'b0; bt_hold <= 1'b0;
      sat <= 1'b0; unsat <= 1'b0; imply_pop <= 1'b0; imply_flush <= 1'b0;
      trace_pop <= 1'b0; trace_push <= 1'b0; trace_din <= '0;
      vs_write <= 1'b0; vs_data <= '0; vse_read <= 1'b0; dec_req <= 1'b0; bcp_clear <= 1'b0;
    end else begin
      state <= nxt; idx <= idx_d; end_r <= end_d; conf_flag <= conf_d; bt_hold <= hold_d;
      sat <= (nxt == S_SAT); unsat <= (nxt == S_UNSAT);
      imply_pop <= ipop_d; imply_flush <= flush_d;
      trace_pop <= tpop_d; trace_push <= tpush_d; trace_din <= tdin_d;
      vs_write <= vsw_d; vs_data <= vsd_d; vse_read <= vser_d;
      dec_req <= (nxt == S_DECIDE); bcp_clear <= clear_d;
    end
  end

`ifdef DPLL_STATS_EN
  logic dec_push, bt_entry;
  assign dec_push = (state == S_DECIDE) && dec_valid && !dec_none;
  assign bt_entry = (nxt == S_BACKTRACK) && (state != S_BACKTRACK);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      num_decisions <= '0;
      num_conflicts <= '0;
    end else begin
      if (dec_push && (num_decisions != 16'hFFFF)) num_decisions <= num_decisions + 16'd1;
      if (bt_entry && (num_conflicts != 16'hFFFF)) num_conflicts <= num_conflicts + 16'd1;
    end
  end
`endif
endmodule
